// File: rtl/expr_seq_pkg.sv
// Shared types, default widths and the result fold for the expression vector sequencer.
package expr_seq_pkg;

   localparam int unsigned AW_DEF = 30;
   localparam int unsigned YW_DEF = 90;
   localparam int unsigned SW     = 32;
   localparam int unsigned CW     = 4;
   localparam int unsigned IW     = 16;

   localparam logic [SW-1:0] SIG_SEED_DEF = 32'hFFFF_FFFF;
   localparam logic [SW-1:0] SIG_POLY_DEF = 32'h04C1_1DB7;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD, S_DONE} state_t;

   // Reduce a 90-bit datapath result to one 32-bit MISR input word.
   function automatic logic [SW-1:0] sig_fold(input logic [YW_DEF-1:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

endpackage

// File: rtl/expr_seq_misr.sv
// 32-bit MISR: seed load at batch start, one shift/XOR step per captured result.
module expr_seq_misr
   import expr_seq_pkg::*;
#(
   parameter logic [SW-1:0] SEED = SIG_SEED_DEF,
   parameter logic [SW-1:0] POLY = SIG_POLY_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          seed_load,
   input  logic          upd_en,
   input  logic [SW-1:0] din,
   output logic [SW-1:0] sig
);

   // Signature register; seed load wins over update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= SEED;
      end else if (seed_load) begin
         sig <= SEED;
      end else if (upd_en) begin
         sig <= {sig[SW-2:0], 1'b0} ^ (sig[SW-1] ? POLY : '0) ^ din;
      end
   end

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives operand vectors into an expression datapath, waits SETTLE cycles,
// captures y onto a valid/ready stream and folds it into a batch signature.
// Optional signature compare ports: define EXPR_SEQ_SIGCHK_EN.
module expr_vector_sequencer
   import expr_seq_pkg::*;
#(
   parameter int unsigned AW       = AW_DEF,
   parameter int unsigned YW       = YW_DEF,
   parameter int unsigned SETTLE   = 1,
   parameter logic [31:0] SIG_SEED = SIG_SEED_DEF,
   parameter logic [31:0] SIG_POLY = SIG_POLY_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_a,
   input  logic [AW-1:0] in_b,
   input  logic          in_last,
   output logic [AW-1:0] op_a,
   output logic [AW-1:0] op_b,
   input  logic [YW-1:0] y_in,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [YW-1:0] res_y,
   output logic [IW-1:0] res_idx,
   output logic          sig_valid,
   output logic [31:0]   sig
`ifdef EXPR_SEQ_SIGCHK_EN
   ,
   input  logic [31:0]   exp_sig,
   output logic          sig_match,
   output logic          sig_fail
`endif
);

   state_t          state, state_n;
   logic [CW-1:0]   cnt;
   logic            last_q;
   logic            batch_start;
   logic            accept_c, capture_c, release_c, finish_c;
   logic [SW-1:0]   fold_c;

   assign fold_c = sig_fold(y_in);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next state and per-cycle event strobes.
   always_comb begin
      state_n   = state;
      accept_c  = 1'b0;
      capture_c = 1'b0;
      release_c = 1'b0;
      finish_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               accept_c = 1'b1;
               state_n  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               capture_c = 1'b1;
               state_n   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (res_valid && res_ready) begin
               release_c = 1'b1;
               state_n   = last_q ? S_DONE : S_IDLE;
            end
         end
         S_DONE: begin
            finish_c = 1'b1;
            state_n  = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Operand, result, index and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready    <= 1'b1;
         sig_valid   <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         last_q      <= 1'b0;
         cnt         <= '0;
         batch_start <= 1'b1;
         res_valid   <= 1'b0;
         res_y       <= '0;
         res_idx     <= '0;
      end else begin
         in_ready  <= (state_n == S_IDLE);
         sig_valid <= (state_n == S_DONE);
         if (accept_c) begin
            op_a   <= in_a;
            op_b   <= in_b;
            last_q <= in_last;
            cnt    <= CW'(SETTLE - 1);
            if (batch_start) begin
               res_idx     <= '0;
               batch_start <= 1'b0;
            end
         end else if (state == S_SETTLE) begin
            cnt <= cnt - CW'(1);
         end
         if (capture_c) begin
            res_y     <= y_in;
            res_valid <= 1'b1;
         end
         if (release_c) begin
            res_valid <= 1'b0;
            res_idx   <= res_idx + IW'(1);
         end
         if (finish_c) batch_start <= 1'b1;
      end
   end

   // Batch signature: reseeded at the first vector of each batch.
   expr_seq_misr #(
      .SEED (SIG_SEED),
      .POLY (SIG_POLY)
   ) u_misr (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (accept_c & batch_start),
      .upd_en    (capture_c),
      .din       (fold_c),
      .sig       (sig)
   );

`ifdef EXPR_SEQ_SIGCHK_EN
   // Sticky compare flags, cleared when the next batch starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_match <= 1'b0;
         sig_fail  <= 1'b0;
      end else if (finish_c) begin
         sig_match <= (sig == exp_sig);
         sig_fail  <= (sig != exp_sig);
      end else if (accept_c && batch_start) begin
         sig_match <= 1'b0;
         sig_fail  <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed bench: one sequencer with SETTLE=1 and one with SETTLE=3.
module tb_expr_vector_sequencer;

   localparam logic [31:0] SEED = 32'hFFFF_FFFF;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic        d1_in_valid, d1_in_ready, d1_in_last, d1_res_valid, d1_res_ready, d1_sig_valid;
   logic [29:0] d1_in_a, d1_in_b, d1_op_a, d1_op_b;
   logic [89:0] d1_y_in, d1_res_y;
   logic [15:0] d1_res_idx;
   logic [31:0] d1_sig;

   logic        d3_in_valid, d3_in_ready, d3_in_last, d3_res_valid, d3_res_ready, d3_sig_valid;
   logic [29:0] d3_in_a, d3_in_b, d3_op_a, d3_op_b;
   logic [89:0] d3_y_in, d3_res_y;
   logic [15:0] d3_res_idx;
   logic [31:0] d3_sig;

`ifdef EXPR_SEQ_SIGCHK_EN
   logic [31:0] d1_exp_sig, d3_exp_sig;
   logic        d1_sig_match, d1_sig_fail, d3_sig_match, d3_sig_fail;
`endif

   always #5 clk = ~clk;

   expr_vector_sequencer #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready),
      .in_a(d1_in_a), .in_b(d1_in_b), .in_last(d1_in_last),
      .op_a(d1_op_a), .op_b(d1_op_b), .y_in(d1_y_in),
      .res_valid(d1_res_valid), .res_ready(d1_res_ready),
      .res_y(d1_res_y), .res_idx(d1_res_idx),
      .sig_valid(d1_sig_valid), .sig(d1_sig)
`ifdef EXPR_SEQ_SIGCHK_EN
      , .exp_sig(d1_exp_sig), .sig_match(d1_sig_match), .sig_fail(d1_sig_fail)
`endif
   );

   expr_vector_sequencer #(.SETTLE(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(d3_in_valid), .in_ready(d3_in_ready),
      .in_a(d3_in_a), .in_b(d3_in_b), .in_last(d3_in_last),
      .op_a(d3_op_a), .op_b(d3_op_b), .y_in(d3_y_in),
      .res_valid(d3_res_valid), .res_ready(d3_res_ready),
      .res_y(d3_res_y), .res_idx(d3_res_idx),
      .sig_valid(d3_sig_valid), .sig(d3_sig)
`ifdef EXPR_SEQ_SIGCHK_EN
      , .exp_sig(d3_exp_sig), .sig_match(d3_sig_match), .sig_fail(d3_sig_fail)
`endif
   );

   function automatic logic [31:0] fold_m(input logic [89:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

   function automatic logic [31:0] misr_m(input logic [31:0] s, input logic [31:0] d);
      return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ d;
   endfunction

   task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full vector on the SETTLE=1 instance, with bounded waits.
   task automatic d1_vec(input logic [29:0] a, input logic [29:0] b, input logic last,
                         input logic [89:0] y, input int idx, input logic [31:0] sexp);
      int n;
      n = 0;
      while (!d1_in_ready && n < 20) begin tick(); n++; end
      check("vec_in_ready", d1_in_ready, 1'b1);
      d1_in_valid = 1'b1; d1_in_a = a; d1_in_b = b; d1_in_last = last; d1_y_in = y;
      tick();
      d1_in_valid = 1'b0;
      check("vec_op_a", d1_op_a, a);
      n = 0;
      while (!d1_res_valid && n < 20) begin tick(); n++; end
      check("vec_res_valid", d1_res_valid, 1'b1);
      check("vec_res_y", d1_res_y, y);
      check("vec_res_idx", d1_res_idx, 16'(idx));
      check("vec_sig", d1_sig, sexp);
      d1_res_ready = 1'b1;
      tick();
      d1_res_ready = 1'b0;
      check("vec_res_drop", d1_res_valid, 1'b0);
      if (last) begin
         check("vec_sig_valid", d1_sig_valid, 1'b1);
         check("vec_sig_final", d1_sig, sexp);
      end
   endtask

   logic [89:0] yv [3];
   logic [29:0] av [3];
   logic [31:0] s;
   logic [89:0] y_bp, y_a, y_b, y_c, y_d;

   initial begin
      d1_in_valid = 0; d1_in_last = 0; d1_res_ready = 0; d1_in_a = '0; d1_in_b = '0; d1_y_in = '0;
      d3_in_valid = 0; d3_in_last = 0; d3_res_ready = 0; d3_in_a = '0; d3_in_b = '0; d3_y_in = '0;
`ifdef EXPR_SEQ_SIGCHK_EN
      d1_exp_sig = '0; d3_exp_sig = '0;
`endif
      yv[0] = 90'h123_4567_89AB_CDEF_0123_4567;
      yv[1] = 90'h3FF_0000_FFFF_0000_FFFF_A5A5;
      yv[2] = 90'h0AA_5555_AAAA_1234_8765_0F0F;
      av[0] = 30'h0000_0011; av[1] = 30'h1555_5555; av[2] = 30'h3FFF_FFFF;
      y_bp = 90'h2DE_ADBE_EF00_CAFE_F00D_1234;
      y_a  = 90'h111_1111_1111_1111_1111_1111;
      y_b  = 90'h222_2222_2222_2222_2222_2222;
      y_c  = 90'h333_3333_3333_3333_3333_3333;
      y_d  = 90'h0F0_F0F0_1234_5678_9ABC_DEF0;

      // Reset values
      #3 rst_n = 1'b0;
      tick(); tick();
      check("rst_in_ready", d1_in_ready, 1'b1);
      check("rst_res_valid", d1_res_valid, 1'b0);
      check("rst_sig_valid", d1_sig_valid, 1'b0);
      check("rst_sig", d1_sig, SEED);
      check("rst_op_a", d1_op_a, 30'h0);
      check("rst_op_b", d1_op_b, 30'h0);
      check("rst_res_y", d1_res_y, 90'h0);
      check("rst_res_idx", d1_res_idx, 16'h0);
      check("rst_sig_d3", d3_sig, SEED);
      rst_n = 1'b1;
      tick();

      // Single vector, SETTLE=1, y=0
`ifdef EXPR_SEQ_SIGCHK_EN
      d1_exp_sig = 32'hFB3E_E248;
`endif
      d1_in_valid = 1'b1; d1_in_a = 30'h1; d1_in_b = 30'h2; d1_in_last = 1'b1; d1_y_in = 90'h0;
      tick();
      d1_in_valid = 1'b0;
      check("t1_op_a", d1_op_a, 30'h1);
      check("t1_op_b", d1_op_b, 30'h2);
      check("t1_in_ready_low", d1_in_ready, 1'b0);
      tick();
      check("t1_res_valid", d1_res_valid, 1'b1);
      check("t1_res_y", d1_res_y, 90'h0);
      check("t1_res_idx", d1_res_idx, 16'h0);
      check("t1_sig", d1_sig, 32'hFB3E_E249);
      d1_res_ready = 1'b1;
      tick();
      d1_res_ready = 1'b0;
      check("t1_res_drop", d1_res_valid, 1'b0);
      check("t1_sig_valid", d1_sig_valid, 1'b1);
      tick();
      check("t1_sig_valid_pulse", d1_sig_valid, 1'b0);
      check("t1_in_ready_back", d1_in_ready, 1'b1);
      check("t1_sig_hold", d1_sig, 32'hFB3E_E249);
`ifdef EXPR_SEQ_SIGCHK_EN
      check("t1_sig_fail", d1_sig_fail, 1'b1);
      check("t1_sig_match", d1_sig_match, 1'b0);
`endif

      // res_ready while idle is ignored; operands retained
      d1_res_ready = 1'b1;
      tick(); tick();
      d1_res_ready = 1'b0;
      check("idle_res_valid", d1_res_valid, 1'b0);
      check("idle_res_idx", d1_res_idx, 16'h1);
      check("idle_op_a_keep", d1_op_a, 30'h1);
      check("idle_sig_keep", d1_sig, 32'hFB3E_E249);

      // Result backpressure
      s = misr_m(SEED, fold_m(y_bp));
      d1_in_valid = 1'b1; d1_in_a = 30'h2AAA_AAAA; d1_in_b = 30'h1234_5678; d1_in_last = 1'b1; d1_y_in = y_bp;
      tick();
      d1_in_valid = 1'b0;
      check("bp_idx_clear", d1_res_idx, 16'h0);
`ifdef EXPR_SEQ_SIGCHK_EN
      check("bp_fail_clear", d1_sig_fail, 1'b0);
      check("bp_match_clear", d1_sig_match, 1'b0);
      d1_exp_sig = s;
`endif
      tick();
      d1_y_in = 90'h0;
      for (int i = 0; i < 5; i++) begin
         check("bp_res_valid", d1_res_valid, 1'b1);
         check("bp_res_y", d1_res_y, y_bp);
         check("bp_res_idx", d1_res_idx, 16'h0);
         check("bp_in_ready", d1_in_ready, 1'b0);
         check("bp_sig", d1_sig, s);
         tick();
      end
      d1_res_ready = 1'b1;
      tick();
      d1_res_ready = 1'b0;
      check("bp_sig_valid", d1_sig_valid, 1'b1);
      check("bp_sig_final", d1_sig, s);
      tick();
`ifdef EXPR_SEQ_SIGCHK_EN
      check("bp_sig_match", d1_sig_match, 1'b1);
      check("bp_sig_fail", d1_sig_fail, 1'b0);
`endif

      // Two identical batches of three vectors
      for (int r = 0; r < 2; r++) begin
         s = SEED;
         for (int i = 0; i < 3; i++) begin
            s = misr_m(s, fold_m(yv[i]));
            d1_vec(av[i], ~av[i], (i == 2), yv[i], i, s);
         end
      end

      // SETTLE=3: capture uses y_in at the third edge after acceptance
      d3_in_valid = 1'b1; d3_in_a = 30'h0ABC_DEF0; d3_in_b = 30'h3000_0001; d3_in_last = 1'b1; d3_y_in = y_a;
      tick();
      d3_in_valid = 1'b0; d3_y_in = y_b;
      check("s3_op_b", d3_op_b, 30'h3000_0001);
      check("s3_rdy_t0", d3_in_ready, 1'b0);
      check("s3_rv_t0", d3_res_valid, 1'b0);
      tick();
      d3_y_in = y_c;
      check("s3_rdy_t1", d3_in_ready, 1'b0);
      check("s3_rv_t1", d3_res_valid, 1'b0);
      tick();
      d3_y_in = y_d;
      check("s3_rdy_t2", d3_in_ready, 1'b0);
      check("s3_rv_t2", d3_res_valid, 1'b0);
      tick();
      check("s3_rv_t3", d3_res_valid, 1'b1);
      check("s3_res_y", d3_res_y, y_d);
      check("s3_sig", d3_sig, misr_m(SEED, fold_m(y_d)));
      d3_res_ready = 1'b1;
      tick();
      d3_res_ready = 1'b0;
      check("s3_sig_valid", d3_sig_valid, 1'b1);
      tick();
`ifdef EXPR_SEQ_SIGCHK_EN
      check("s3_sig_fail", d3_sig_fail, 1'b1);
      check("s3_sig_match", d3_sig_match, 1'b0);
`endif

      // Reset during SETTLE of the second vector of a batch
      d3_in_valid = 1'b1; d3_in_a = 30'h0000_0055; d3_in_last = 1'b0; d3_y_in = y_a;
      tick();
      d3_in_valid = 1'b0;
      tick(); tick(); tick();
      check("mr_v1_valid", d3_res_valid, 1'b1);
      d3_res_ready = 1'b1;
      tick();
      d3_res_ready = 1'b0;
      check("mr_v1_idx", d3_res_idx, 16'h1);
      check("mr_v2_ready", d3_in_ready, 1'b1);
      d3_in_valid = 1'b1; d3_in_a = 30'h0000_0066; d3_in_last = 1'b1; d3_y_in = y_b;
      tick();
      d3_in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      check("mr_in_ready", d3_in_ready, 1'b1);
      check("mr_res_valid", d3_res_valid, 1'b0);
      check("mr_sig", d3_sig, SEED);
      check("mr_op_a", d3_op_a, 30'h0);
      check("mr_res_y", d3_res_y, 90'h0);
      check("mr_res_idx", d3_res_idx, 16'h0);
      rst_n = 1'b1;
      tick();

      // Fresh batch after reset matches the earlier single-vector signature
      d3_in_valid = 1'b1; d3_in_a = 30'h0ABC_DEF0; d3_in_last = 1'b1; d3_y_in = y_d;
      tick();
      d3_in_valid = 1'b0;
      tick(); tick(); tick();
      check("fr_res_y", d3_res_y, y_d);
      check("fr_res_idx", d3_res_idx, 16'h0);
      check("fr_sig", d3_sig, misr_m(SEED, fold_m(y_d)));
      d3_res_ready = 1'b1;
      tick();
      d3_res_ready = 1'b0;
      check("fr_sig_valid", d3_sig_valid, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
